// File: rtl/vx_tcu_fedp_drain.sv
// Drain stage behind the FEDP pipeline: tracks request valid/tag alongside the
// enable-gated datapath and buffers completed dot products for writeback.
module vx_tcu_fedp_drain #(
  parameter int LATENCY = 16,
  parameter int TAGW    = 8,
  parameter int DEPTH   = 4,
  parameter int XLEN    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic [TAGW-1:0]              tag_in,
  output logic                         ready_in,
  output logic                         fedp_enable,
  input  logic [XLEN-1:0]              fedp_d_val,
  output logic                         valid_out,
  output logic [XLEN-1:0]              d_out,
  output logic [TAGW-1:0]              tag_out,
  input  logic                         ready_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy
);

  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PTRW = $clog2(DEPTH);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [LATENCY-1:0] sh_vld;
  logic [TAGW-1:0]    sh_tag [LATENCY];

  logic [XLEN-1:0]    mem_d   [DEPTH];
  logic [TAGW-1:0]    mem_tag [DEPTH];
  logic [PTRW-1:0]    wr_ptr;
  logic [PTRW-1:0]    rd_ptr;
  logic [CNTW-1:0]    cnt_q;

  logic tail_vld;
  logic any_vld;
  logic fifo_nonempty;
  logic full;
  logic pop;
  logic stall;
  logic push;

  // A valid tail may only advance if the FIFO can take it this cycle; otherwise
  // the whole FEDP is frozen so its tail result stays put on fedp_d_val.
  always_comb begin
    tail_vld      = sh_vld[LATENCY-1];
    any_vld       = |sh_vld;
    fifo_nonempty = (cnt_q != '0);
    full          = (cnt_q == FULL_CNT);
    valid_out     = reset && fifo_nonempty;
    pop           = valid_out && ready_out;
    stall         = tail_vld && full && !pop;
    ready_in      = reset && !stall;
    fedp_enable   = reset && !stall && (valid_in || any_vld);
    push          = fedp_enable && tail_vld;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sh_vld <= '0;
    end else if (fedp_enable) begin
      for (int k = LATENCY - 1; k > 0; k--) begin
        sh_vld[k] <= sh_vld[k-1];
      end
      sh_vld[0] <= valid_in && ready_in;
    end
  end

  // Tags are qualified by sh_vld, so they need no reset.
  always_ff @(posedge clk) begin
    if (fedp_enable) begin
      for (int k = LATENCY - 1; k > 0; k--) begin
        sh_tag[k] <= sh_tag[k-1];
      end
      sh_tag[0] <= tag_in;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_d[wr_ptr]   <= fedp_d_val;
      mem_tag[wr_ptr] <= sh_tag[LATENCY-1];
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTRW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTRW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNTW'(1);
        2'b01:   cnt_q <= cnt_q - CNTW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    d_out   = mem_d[rd_ptr];
    tag_out = mem_tag[rd_ptr];
    count   = cnt_q;
    busy    = any_vld || fifo_nonempty;
  end

endmodule

// File: tb/tb_vx_tcu_fedp_drain.sv
// Bench for vx_tcu_fedp_drain: a delay-LATENCY FEDP stand-in feeds the DUT and an
// issue-order queue of {tag, data} predicts every result leaving the FIFO.
module tb_vx_tcu_fedp_drain;

  localparam int LATENCY = 16;
  localparam int TAGW    = 8;
  localparam int DEPTH   = 4;
  localparam int XLEN    = 32;
  localparam int CW      = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in;
  logic [TAGW-1:0]   tag_in;
  logic              ready_in;
  logic              fedp_enable;
  logic [XLEN-1:0]   fedp_d_val;
  logic              valid_out;
  logic [XLEN-1:0]   d_out;
  logic [TAGW-1:0]   tag_out;
  logic              ready_out;
  logic [CW-1:0]     count;
  logic              busy;

  logic [XLEN-1:0]   fedp_a;
  logic [XLEN-1:0]   fedp_pipe [LATENCY];

  int checks   = 0;
  int failures = 0;

  logic [TAGW+XLEN-1:0] exp_q [$];

  logic                 o_ready_in;
  logic                 o_enable;
  logic                 o_valid_out;
  logic                 o_busy;
  logic [CW-1:0]        o_count;
  logic [TAGW-1:0]      o_tag;
  logic [XLEN-1:0]      o_d;
  logic                 o_acc;
  logic                 o_pop;
  logic                 o_exp_ok;
  logic [TAGW+XLEN-1:0] o_exp;
  int                   o_outstanding;

  vx_tcu_fedp_drain #(
    .LATENCY(LATENCY), .TAGW(TAGW), .DEPTH(DEPTH), .XLEN(XLEN)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .tag_in(tag_in),
    .ready_in(ready_in), .fedp_enable(fedp_enable), .fedp_d_val(fedp_d_val),
    .valid_out(valid_out), .d_out(d_out), .tag_out(tag_out),
    .ready_out(ready_out), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in FEDP: a plain enable-gated delay line of LATENCY stages.
  always @(posedge clk) begin
    if (fedp_enable) begin
      for (int k = LATENCY - 1; k > 0; k--) fedp_pipe[k] <= fedp_pipe[k-1];
      fedp_pipe[0] <= fedp_a;
    end
  end
  assign fedp_d_val = fedp_pipe[LATENCY-1];

  // One clock: drive inputs after a falling edge, sample just after, then let
  // the rising edge happen. Popped entries are taken from the queue before the
  // accepted one is appended.
  task automatic cycle(input logic v, input logic [TAGW-1:0] t,
                       input logic [XLEN-1:0] a, input logic r);
    valid_in  = v;
    tag_in    = t;
    fedp_a    = a;
    ready_out = r;
    #2;
    o_ready_in    = ready_in;
    o_enable      = fedp_enable;
    o_valid_out   = valid_out;
    o_busy        = busy;
    o_count       = count;
    o_tag         = tag_out;
    o_d           = d_out;
    o_acc         = valid_in && ready_in;
    o_pop         = valid_out && ready_out;
    o_outstanding = exp_q.size();
    o_exp_ok      = 1'b0;
    o_exp         = '0;
    if (o_pop && exp_q.size() != 0) begin
      o_exp    = exp_q.pop_front();
      o_exp_ok = 1'b1;
    end
    if (o_acc) exp_q.push_back({t, a});
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 8'hAA, $urandom, 1'b1);
      checks++;
      if (o_ready_in !== 1'b0 || o_enable !== 1'b0 || o_valid_out !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_forced: ready_in=%b fedp_enable=%b valid_out=%b, expected all 0",
                 o_ready_in, o_enable, o_valid_out);
      end
    end
    reset = 1'b1;
    cycle(1'b0, '0, $urandom, 1'b1);
    checks++;
    if (o_ready_in !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready_in: got %b, expected 1", o_ready_in);
    end
    checks++;
    if (o_valid_out !== 1'b0 || o_count !== '0 || o_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: valid_out=%b count=%0d busy=%b, expected 0/0/0",
               o_valid_out, o_count, o_busy);
    end
  endtask

  task automatic test_single();
    logic [XLEN-1:0] data;
    int first_valid;
    int en_cnt;
    data        = $urandom;
    first_valid = -1;
    en_cnt      = 0;
    cycle(1'b1, 8'h5A, data, 1'b1);
    checks++;
    if (o_acc !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_accept: accept=%b, expected 1", o_acc);
    end
    for (int k = 1; k <= 40; k++) begin
      cycle(1'b0, '0, $urandom, 1'b1);
      if (o_enable) en_cnt++;
      if (first_valid > 0 && k == first_valid + 1) begin
        checks++;
        if (o_busy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL single_busy_drop: busy=%b after pop, expected 0", o_busy);
        end
      end
      if (o_valid_out && first_valid < 0) first_valid = k;
      if (o_pop) begin
        checks++;
        if (!o_exp_ok || o_tag !== 8'h5A || o_d !== data) begin
          failures++;
          $display("[TB] FAIL single_result: got tag=%h d=%h, expected tag=5a d=%h",
                   o_tag, o_d, data);
        end
      end
    end
    checks++;
    if (first_valid != LATENCY + 1) begin
      failures++;
      $display("[TB] FAIL single_latency: valid_out after %0d cycles, expected %0d",
               first_valid, LATENCY + 1);
    end
    checks++;
    if (en_cnt != LATENCY) begin
      failures++;
      $display("[TB] FAIL single_enable_cycles: enable high %0d cycles after accept, expected %0d",
               en_cnt, LATENCY);
    end
    checks++;
    if (exp_q.size() != 0 || o_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_drain: %0d results outstanding, busy=%b, expected 0/0",
               exp_q.size(), o_busy);
    end
  endtask

  task automatic test_back_to_back();
    int npop;
    int fp;
    npop = 0;
    fp   = 0;
    for (int k = 0; k < 60; k++) begin
      cycle(k < 20, TAGW'(k), $urandom, 1'b1);
      if (k < 20) begin
        checks++;
        if (o_acc !== 1'b1) begin
          failures++;
          $display("[TB] FAIL b2b_accept: request %0d not accepted (ready_in=%b)", k, o_ready_in);
        end
      end
      checks++;
      if (o_count > CW'(1)) begin
        failures++;
        $display("[TB] FAIL b2b_count: count=%0d at cycle %0d, expected <=1", o_count, k);
      end
      if (o_pop) begin
        checks++;
        if (!o_exp_ok || {o_tag, o_d} !== o_exp || o_tag !== TAGW'(npop)) begin
          failures++;
          $display("[TB] FAIL b2b_order: got tag=%h d=%h, expected %h (tag %0d)",
                   o_tag, o_d, o_exp, npop);
        end
        if (npop == 0) fp = k;
        checks++;
        if (k != fp + npop) begin
          failures++;
          $display("[TB] FAIL b2b_gap: result %0d at cycle %0d, expected cycle %0d", npop, k, fp + npop);
        end
        npop++;
      end
    end
    checks++;
    if (npop != 20 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL b2b_total: %0d results out, %0d missing, expected 20/0", npop, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int  issued;
    int  npop;
    bit  saw_full;
    bit  saw_stall;
    issued    = 0;
    npop      = 0;
    saw_full  = 0;
    saw_stall = 0;
    for (int k = 0; k < 50; k++) begin
      cycle(issued < 8, TAGW'(8'h80 + issued), $urandom, 1'b0);
      if (o_acc) issued++;
      if (o_count == CW'(DEPTH)) saw_full = 1;
      if (!o_ready_in) begin
        saw_stall = 1;
        checks++;
        if (o_enable !== 1'b0) begin
          failures++;
          $display("[TB] FAIL bp_enable: fedp_enable=%b while ready_in=0, expected 0", o_enable);
        end
      end
    end
    checks++;
    if (!saw_full || !saw_stall || issued != 8) begin
      failures++;
      $display("[TB] FAIL bp_fill: full=%0d stall=%0d issued=%0d, expected 1/1/8",
               saw_full, saw_stall, issued);
    end
    checks++;
    if (o_count !== CW'(DEPTH) || o_ready_in !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_hold: count=%0d ready_in=%b, expected %0d/0", o_count, o_ready_in, DEPTH);
    end
    for (int k = 0; k < 60; k++) begin
      cycle(1'b0, '0, $urandom, 1'b1);
      if (o_pop) begin
        checks++;
        if (!o_exp_ok || {o_tag, o_d} !== o_exp || o_tag !== TAGW'(8'h80 + npop)) begin
          failures++;
          $display("[TB] FAIL bp_order: got tag=%h d=%h, expected %h", o_tag, o_d, o_exp);
        end
        npop++;
      end
    end
    checks++;
    if (npop != 8 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL bp_total: %0d results out, %0d missing, expected 8/0", npop, exp_q.size());
    end
  endtask

  task automatic test_full_pushpop();
    int issued;
    int npop;
    bit stalled;
    issued  = 0;
    npop    = 0;
    stalled = 0;
    reset = 1'b0;
    cycle(1'b0, '0, $urandom, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 60; k++) begin
      cycle(issued < 6, TAGW'(8'h40 + issued), $urandom, 1'b0);
      if (o_acc) issued++;
      if (!o_ready_in) begin
        stalled = 1;
        break;
      end
    end
    checks++;
    if (!stalled || o_count !== CW'(DEPTH)) begin
      failures++;
      $display("[TB] FAIL full_setup: stalled=%0d count=%0d, expected 1/%0d", stalled, o_count, DEPTH);
    end
    cycle(1'b0, '0, $urandom, 1'b1);
    checks++;
    if (o_ready_in !== 1'b1 || o_enable !== 1'b1 || o_pop !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_no_stall: ready_in=%b enable=%b pop=%b, expected 1/1/1",
               o_ready_in, o_enable, o_pop);
    end
    checks++;
    if (!o_exp_ok || {o_tag, o_d} !== o_exp) begin
      failures++;
      $display("[TB] FAIL full_pop_value: got tag=%h d=%h, expected %h", o_tag, o_d, o_exp);
    end
    cycle(1'b0, '0, $urandom, 1'b0);
    checks++;
    if (o_count !== CW'(DEPTH) || o_valid_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_count_hold: count=%0d valid_out=%b, expected %0d/1",
               o_count, o_valid_out, DEPTH);
    end
    for (int k = 0; k < 60; k++) begin
      cycle(1'b0, '0, $urandom, 1'b1);
      if (o_pop) begin
        checks++;
        if (!o_exp_ok || {o_tag, o_d} !== o_exp || o_tag !== TAGW'(8'h41 + npop)) begin
          failures++;
          $display("[TB] FAIL full_wrap_order: got tag=%h d=%h, expected %h", o_tag, o_d, o_exp);
        end
        npop++;
      end
    end
    checks++;
    if (npop != 5 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL full_total: %0d results out, %0d missing, expected 5/0", npop, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    logic [XLEN-1:0] data;
    int npop;
    npop = 0;
    for (int k = 0; k < 19; k++) begin
      cycle(k < 8, TAGW'(8'h20 + k), $urandom, 1'b0);
    end
    reset = 1'b0;
    cycle(1'b1, 8'hEE, $urandom, 1'b0);
    checks++;
    if (o_count !== CW'(3) || o_valid_out !== 1'b0 || o_ready_in !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_pre: count=%0d valid_out=%b ready_in=%b, expected 3/0/0",
               o_count, o_valid_out, o_ready_in);
    end
    reset = 1'b1;
    exp_q.delete();
    data = $urandom;
    cycle(1'b1, 8'h11, data, 1'b1);
    checks++;
    if (o_valid_out !== 1'b0 || o_count !== '0 || o_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_clear: valid_out=%b count=%0d busy=%b, expected 0/0/0",
               o_valid_out, o_count, o_busy);
    end
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0, '0, $urandom, 1'b1);
      if (o_pop) begin
        checks++;
        if (!o_exp_ok || o_tag !== 8'h11 || o_d !== data) begin
          failures++;
          $display("[TB] FAIL midrst_stale: got tag=%h d=%h, expected tag=11 d=%h", o_tag, o_d, data);
        end
        npop++;
      end
    end
    checks++;
    if (npop != 1 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL midrst_total: %0d results out, %0d missing, expected 1/0", npop, exp_q.size());
    end
  endtask

  task automatic test_random_soak();
    for (int k = 0; k < 10000; k++) begin
      cycle(1'($urandom_range(0, 1)), TAGW'($urandom), $urandom, 1'($urandom_range(0, 1)));
      checks++;
      if (o_count > CW'(DEPTH) || o_busy !== (o_outstanding != 0)) begin
        failures++;
        $display("[TB] FAIL soak_state: cycle %0d count=%0d busy=%b, outstanding=%0d",
                 k, o_count, o_busy, o_outstanding);
      end
      checks++;
      if (!o_ready_in && (o_outstanding <= DEPTH || o_enable !== 1'b0)) begin
        failures++;
        $display("[TB] FAIL soak_stall: cycle %0d ready_in=0 enable=%b with %0d outstanding",
                 k, o_enable, o_outstanding);
      end
      if (o_pop) begin
        checks++;
        if (!o_exp_ok || {o_tag, o_d} !== o_exp) begin
          failures++;
          $display("[TB] FAIL soak_order: cycle %0d got tag=%h d=%h, expected %h",
                   k, o_tag, o_d, o_exp);
        end
      end
    end
    for (int k = 0; k < 100; k++) begin
      cycle(1'b0, '0, $urandom, 1'b1);
      if (o_pop) begin
        checks++;
        if (!o_exp_ok || {o_tag, o_d} !== o_exp) begin
          failures++;
          $display("[TB] FAIL soak_drain_order: got tag=%h d=%h, expected %h", o_tag, o_d, o_exp);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || o_enable !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL soak_idle: %0d missing, enable=%b busy=%b, expected 0/0/0",
               exp_q.size(), o_enable, o_busy);
    end
  endtask

  initial begin
    reset     = 1'b0;
    valid_in  = 1'b0;
    tag_in    = '0;
    ready_out = 1'b0;
    fedp_a    = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full_pushpop();
    test_reset_midflight();
    test_random_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
